vdp_io_write_buffer: RTL and testbench
======================================

VDP_IO_WRITE_BUFFER -- requirements
Module: vdp_io_write_buffer

Interface
REQ-001 SHALL have parameter PORT_BASE, default 8'h98: base I/O port of the four VDP ports PORT_BASE..PORT_BASE+3, with bits [1:0] of PORT_BASE equal to zero.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2: FIFO depth of 2**DEPTH_LOG2 entries.
REQ-003 SHALL have one clock and asynchronous active-high reset; no other clock domains.
REQ-004 clk  input  1  system clock, 42.95454MHz.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 bus_address  input  16  slot-side address; only bits [7:0] are decoded.
REQ-007 bus_ioreq  input  1  slot-side I/O request qualifier.
REQ-008 bus_write  input  1  slot-side direction: 1 = write, 0 = read.
REQ-009 bus_valid  input  1  slot-side request valid.
REQ-010 bus_ready  output  1  slot-side request accept.
REQ-011 bus_wdata  input  8  slot-side write data.
REQ-012 bus_rdata  output  8  read data returned to the slot.
REQ-013 bus_rdata_en  output  1  one-cycle strobe marking bus_rdata valid.
REQ-014 vdp_address  output  16  VDP-side address: {8'h00, PORT_BASE[7:2], port[1:0]}.
REQ-015 vdp_ioreq  output  1  VDP-side I/O request; equals vdp_valid.
REQ-016 vdp_write  output  1  VDP-side direction.
REQ-017 vdp_valid  output  1  VDP-side request valid.
REQ-018 vdp_ready  input  1  VDP-side request accept.
REQ-019 vdp_wdata  output  8  VDP-side write data.
REQ-020 vdp_rdata  input  8  VDP-side read data.
REQ-021 vdp_rdata_en  input  1  VDP-side read data strobe.

Function
REQ-022 Acceptance: a slot request SHALL be accepted in any cycle where bus_valid=1 and bus_ready=1.
REQ-023 bus_ready SHALL be 1 only when the state is IDLE and the FIFO count is less than the depth; it is derived from registered state only, so no same-cycle pop credit is taken.
REQ-024 VDP-port match: an accepted request with bus_ioreq=1 and bus_address[7:2]=PORT_BASE[7:2] SHALL push the entry {write, address[1:0], wdata} into the FIFO.
REQ-025 Non-matching requests (memreq, or any other port) SHALL be accepted and dropped: no push, no bus_rdata_en.
REQ-026 FIFO head: vdp_valid SHALL be high whenever the FIFO is non-empty and the state is not RD_WAIT; vdp_write, vdp_address and vdp_wdata SHALL present the head entry and stay stable until vdp_valid=1 and vdp_ready=1, at which point the head is popped.
REQ-027 Latency: a push into an empty FIFO SHALL produce vdp_valid=1 on the next clock.
REQ-028 A simultaneous push and pop SHALL leave the count unchanged; pointers wrap modulo the depth.
REQ-029 State machine: IDLE, RD_PEND, RD_WAIT.
REQ-030 IDLE -> RD_PEND on acceptance of a matching read.
REQ-031 RD_PEND -> RD_WAIT when the read entry is popped.
REQ-032 RD_WAIT -> IDLE on vdp_rdata_en=1.
REQ-033 At most one read SHALL be outstanding at any time, and reads SHALL stay in order after all earlier writes.
REQ-034 On vdp_rdata_en=1 in RD_WAIT, bus_rdata SHALL capture vdp_rdata and bus_rdata_en SHALL pulse for exactly one cycle on the following clock.
REQ-035 vdp_rdata_en outside RD_WAIT SHALL be ignored.
REQ-036 In RD_WAIT no further pops SHALL occur, and vdp_valid SHALL be 0.

Reset
REQ-037 On reset the FIFO SHALL be emptied and the pointers zeroed.
REQ-038 On reset the state SHALL be IDLE and bus_ready SHALL be 1 immediately after reset deasserts.
REQ-039 On reset vdp_valid, vdp_ioreq, vdp_write and bus_rdata_en SHALL be 0, and bus_rdata, vdp_address and vdp_wdata SHALL be 0.
REQ-040 Reset mid-operation SHALL discard buffered writes and any pending read; no bus_rdata_en is issued for the discarded read.

Configuration
REQ-041 Macro VDP_WBUF_STAT_EN, when defined, SHALL add output wbuf_level [DEPTH_LOG2:0], the current FIFO count.
REQ-042 Macro VDP_WBUF_STAT_EN, when defined, SHALL add output wbuf_peak [DEPTH_LOG2:0], the sticky maximum count, cleared only by reset.
REQ-043 When VDP_WBUF_STAT_EN is undefined, these ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-044 Burst: vdp_ready=0, then four writes to 0x99 with data 11,22,33,44 -> bus_ready=0 after the 4th; with vdp_ready=1, the VDP sees 11,22,33,44 in order at address 0x0099.
REQ-045 Read ordering: write 0x98<-A5, then immediately read 0x98 -> the read appears at the VDP only after the write handshake; vdp_rdata=5A with vdp_rdata_en -> bus_rdata=5A, bus_rdata_en pulses one cycle later; bus_ready=0 from read acceptance until back in IDLE.
REQ-046 Filtering: write to port 0xA0 and memreq write 0x0098 -> both accepted, vdp_valid stays 0, no bus_rdata_en.
REQ-047 Full with simultaneous pop: FIFO full and vdp_ready=1 -> the count goes to 3, bus_ready rises the next cycle, and no entry is lost or duplicated.
REQ-048 Reset while in RD_WAIT with two writes queued -> all outputs return to 0 and bus_ready=1; a later vdp_rdata_en produces no bus_rdata_en.
REQ-049 With VDP_WBUF_STAT_EN defined: push 3 and drain -> wbuf_level 3->0, wbuf_peak holds 3.

Source files
------------

// File: rtl/vdp_io_write_buffer.sv
// vdp_io_write_buffer: posted-write FIFO between the slot I/O bus and the four VDP ports
//
// Buffers slot-side I/O accesses to PORT_BASE..PORT_BASE+3 and replays them to the VDP
// in order. Reads travel through the same FIFO, so they reach the VDP only after all
// earlier writes. Only one read may be outstanding; its data returns on bus_rdata.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   bus_address/ioreq/write    slot-side request (only bus_address[7:0] decoded)
//   bus_valid/bus_ready        slot-side request handshake
//   bus_wdata                  slot-side write data
//   bus_rdata/bus_rdata_en     read data returned to the slot with a one-cycle strobe
//   vdp_address/ioreq/write    VDP-side request presenting the FIFO head
//   vdp_valid/vdp_ready        VDP-side request handshake
//   vdp_wdata                  VDP-side write data
//   vdp_rdata/vdp_rdata_en     VDP-side read data and strobe
//   wbuf_level/wbuf_peak       current and sticky peak FIFO count (VDP_WBUF_STAT_EN only)
//
// Optional feature macro: VDP_WBUF_STAT_EN
module vdp_io_write_buffer #(
   parameter logic [7:0] PORT_BASE  = 8'h98,
   parameter int         DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           bus_address,
   input  logic                  bus_ioreq,
   input  logic                  bus_write,
   input  logic                  bus_valid,
   output logic                  bus_ready,
   input  logic [7:0]            bus_wdata,
   output logic [7:0]            bus_rdata,
   output logic                  bus_rdata_en,
   output logic [15:0]           vdp_address,
   output logic                  vdp_ioreq,
   output logic                  vdp_write,
   output logic                  vdp_valid,
   input  logic                  vdp_ready,
   output logic [7:0]            vdp_wdata,
   input  logic [7:0]            vdp_rdata,
   input  logic                  vdp_rdata_en
`ifdef VDP_WBUF_STAT_EN
   ,
   output logic [DEPTH_LOG2:0]   wbuf_level,
   output logic [DEPTH_LOG2:0]   wbuf_peak
`endif
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   typedef enum logic [1:0] {IDLE, RD_PEND, RD_WAIT} state_t;
   state_t                state_q, state_d;
   logic [10:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [7:0]            rdata_q, rdata_d;
   logic                  rdata_en_q, rdata_en_d;
   logic [10:0]           head;
   logic                  match, push, pop;
   logic                  unused_addr;
   assign unused_addr = ^bus_address[15:8];
   assign head = mem_q[rd_ptr_q];
   // count never exceeds DEPTH, so its MSB alone flags a full FIFO
   assign bus_ready = (state_q == IDLE) && !count_q[DEPTH_LOG2];
   assign match = bus_ioreq && (bus_address[7:2] == PORT_BASE[7:2]);
   assign push = bus_valid && bus_ready && match;
   assign vdp_valid = (count_q != '0) && (state_q != RD_WAIT);
   assign pop = vdp_valid && vdp_ready;
   assign vdp_ioreq = vdp_valid;
   // head fields are gated so idle outputs read as zero regardless of stale FIFO contents
   assign vdp_write = vdp_valid && head[10];
   assign vdp_address = vdp_valid ? {8'h00, PORT_BASE[7:2], head[9:8]} : 16'h0000;
   assign vdp_wdata = vdp_valid ? head[7:0] : 8'h00;
   assign bus_rdata = rdata_q;
   assign bus_rdata_en = rdata_en_q;
   always_comb begin
      count_d = count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      // a read is always the youngest entry, since acceptance stops until it completes
      state_d = (state_q == IDLE && push && !bus_write)   ? RD_PEND :
                (state_q == RD_PEND && pop && !head[10])  ? RD_WAIT :
                (state_q == RD_WAIT && vdp_rdata_en)      ? IDLE    : state_q;
      rdata_en_d = (state_q == RD_WAIT) && vdp_rdata_en;
      rdata_d = rdata_en_d ? vdp_rdata : rdata_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rdata_q    <= '0;
         rdata_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
         rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
         count_q    <= count_d;
         rdata_q    <= rdata_d;
         rdata_en_q <= rdata_en_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus_write, bus_address[1:0], bus_wdata};
   end
`ifdef VDP_WBUF_STAT_EN
   logic [DEPTH_LOG2:0] peak_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) peak_q <= '0;
      else peak_q <= (count_d > peak_q) ? count_d : peak_q;
   end
   assign wbuf_level = count_q;
   assign wbuf_peak = peak_q;
`endif
endmodule

// File: tb/tb_vdp_io_write_buffer.sv
// tb_vdp_io_write_buffer: directed and randomized bench for vdp_io_write_buffer against a transaction-level model
module tb_vdp_io_write_buffer;
   localparam logic [7:0] BASE  = 8'h98;
   localparam int         DL    = 2;
   localparam int         DEPTH = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] bus_address = '0;
   logic        bus_ioreq = 1'b0, bus_write = 1'b0, bus_valid = 1'b0;
   logic        bus_ready;
   logic [7:0]  bus_wdata = '0, bus_rdata;
   logic        bus_rdata_en;
   logic [15:0] vdp_address;
   logic        vdp_ioreq, vdp_write, vdp_valid;
   logic        vdp_ready = 1'b0;
   logic [7:0]  vdp_wdata;
   logic [7:0]  vdp_rdata = '0;
   logic        vdp_rdata_en = 1'b0;
`ifdef VDP_WBUF_STAT_EN
   logic [DL:0] wbuf_level, wbuf_peak;
`endif
   int vec = 0, bad = 0;

   vdp_io_write_buffer #(.PORT_BASE(BASE), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .reset(reset),
      .bus_address(bus_address), .bus_ioreq(bus_ioreq), .bus_write(bus_write),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en),
      .vdp_address(vdp_address), .vdp_ioreq(vdp_ioreq), .vdp_write(vdp_write),
      .vdp_valid(vdp_valid), .vdp_ready(vdp_ready), .vdp_wdata(vdp_wdata),
      .vdp_rdata(vdp_rdata), .vdp_rdata_en(vdp_rdata_en)
`ifdef VDP_WBUF_STAT_EN
      , .wbuf_level(wbuf_level), .wbuf_peak(wbuf_peak)
`endif
   );

   always #5 clk = ~clk;

   // Model: queue of buffered requests in arrival order plus the read-in-flight flags.
   typedef struct packed {logic w; logic [1:0] p; logic [7:0] d;} ent_t;
   ent_t       mq[$];
   bit         m_rd_out, m_rd_wait, m_en;
   logic [7:0] m_rdata;

   function automatic bit m_ready();
      return !m_rd_out && mq.size() < DEPTH;
   endfunction

   function automatic bit m_valid();
      return mq.size() != 0 && !m_rd_wait;
   endfunction

   task automatic m_clear();
      mq.delete();
      m_rd_out = 0;
      m_rd_wait = 0;
      m_en = 0;
      m_rdata = '0;
   endtask

   task automatic idle();
      bus_valid = 0; bus_ioreq = 0; bus_write = 0; bus_address = '0; bus_wdata = '0;
      vdp_ready = 0; vdp_rdata_en = 0; vdp_rdata = '0;
   endtask

   task automatic req(input logic w, input logic io, input logic [15:0] a, input logic [7:0] d);
      bus_valid = 1; bus_write = w; bus_ioreq = io; bus_address = a; bus_wdata = d;
   endtask

   // Advance one clock from a falling edge, updating the model from the applied inputs.
   task automatic step();
      bit acc, mt, pop, popread, rdret;
      ent_t e;
      logic [7:0] rd;
      acc = bus_valid && m_ready();
      mt = bus_ioreq && (bus_address[7:2] == BASE[7:2]);
      pop = m_valid() && vdp_ready;
      popread = 0;
      if (pop) popread = !mq[0].w;
      rdret = m_rd_wait && vdp_rdata_en;
      rd = vdp_rdata;
      e = {bus_write, bus_address[1:0], bus_wdata};
      @(posedge clk);
      m_en = rdret;
      if (rdret) begin
         m_rdata = rd;
         m_rd_wait = 0;
         m_rd_out = 0;
      end
      if (pop) begin
         void'(mq.pop_front());
         if (popread) m_rd_wait = 1;
      end
      if (acc && mt) begin
         mq.push_back(e);
         if (!e.w) m_rd_out = 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      m_clear();
   endtask

   task automatic test_reset();
      do_reset();
      vec++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus_ready); end
      vec++; if ({vdp_valid, vdp_ioreq, vdp_write, bus_rdata_en} !== 4'b0) begin bad++; $display("FAIL reset_flags got %b want 0000", {vdp_valid, vdp_ioreq, vdp_write, bus_rdata_en}); end
      vec++; if (vdp_address !== 16'h0 || vdp_wdata !== 8'h0 || bus_rdata !== 8'h0) begin bad++; $display("FAIL reset_data got %h/%h/%h want 0/0/0", vdp_address, vdp_wdata, bus_rdata); end
`ifdef VDP_WBUF_STAT_EN
      vec++; if (wbuf_level !== '0 || wbuf_peak !== '0) begin bad++; $display("FAIL reset_stat got %0d/%0d want 0/0", wbuf_level, wbuf_peak); end
`endif
   endtask

   task automatic test_burst();
      logic [7:0] d[4];
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req(1, 1, 16'h0099, d[k]);
         step();
      end
      bus_valid = 0;
      vec++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL burst_full_ready got %b want 0", bus_ready); end
      vdp_ready = 1;
      for (int k = 0; k < 4; k++) begin
         vec++;
         if (vdp_valid !== 1'b1 || vdp_write !== 1'b1 || vdp_address !== 16'h0099 || vdp_wdata !== d[k]) begin
            bad++; $display("FAIL burst_head%0d got v%b w%b %h %h want v1 w1 0099 %h", k, vdp_valid, vdp_write, vdp_address, vdp_wdata, d[k]);
         end
         step();
      end
      vec++; if (vdp_valid !== 1'b0 || bus_ready !== 1'b1) begin bad++; $display("FAIL burst_drained got v%b r%b want v0 r1", vdp_valid, bus_ready); end
   endtask

   task automatic test_read_order();
      do_reset();
      req(1, 1, 16'h0098, 8'hA5);
      step();
      req(0, 1, 16'h0098, 8'h00);
      step();
      bus_valid = 0;
      vec++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL rd_pend_ready got %b want 0", bus_ready); end
      vec++; if (vdp_valid !== 1'b1 || vdp_write !== 1'b1 || vdp_wdata !== 8'hA5) begin bad++; $display("FAIL rd_write_first got v%b w%b %h want v1 w1 a5", vdp_valid, vdp_write, vdp_wdata); end
      vdp_ready = 1;
      step();
      vec++; if (vdp_valid !== 1'b1 || vdp_write !== 1'b0 || vdp_address !== 16'h0098 || bus_ready !== 1'b0) begin bad++; $display("FAIL rd_head got v%b w%b %h r%b want v1 w0 0098 r0", vdp_valid, vdp_write, vdp_address, bus_ready); end
      step();
      vec++; if (vdp_valid !== 1'b0 || bus_ready !== 1'b0 || bus_rdata_en !== 1'b0) begin bad++; $display("FAIL rd_wait got v%b r%b e%b want v0 r0 e0", vdp_valid, bus_ready, bus_rdata_en); end
      vdp_rdata = 8'h5A; vdp_rdata_en = 1;
      step();
      vdp_rdata_en = 0; vdp_rdata = 8'hFF;
      vec++; if (bus_rdata_en !== 1'b1 || bus_rdata !== 8'h5A || bus_ready !== 1'b1) begin bad++; $display("FAIL rd_return got e%b %h r%b want e1 5a r1", bus_rdata_en, bus_rdata, bus_ready); end
      step();
      vec++; if (bus_rdata_en !== 1'b0 || bus_rdata !== 8'h5A) begin bad++; $display("FAIL rd_pulse_end got e%b %h want e0 5a", bus_rdata_en, bus_rdata); end
   endtask

   task automatic test_filter();
      do_reset();
      vdp_ready = 1;
      req(1, 1, 16'h00A0, 8'h77);
      vec++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL filt_port_ready got %b want 1", bus_ready); end
      step();
      req(1, 0, 16'h0098, 8'h66);
      vec++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL filt_mem_ready got %b want 1", bus_ready); end
      step();
      req(0, 1, 16'h00A0, 8'h00);
      step();
      bus_valid = 0;
      for (int k = 0; k < 3; k++) begin
         vec++; if (vdp_valid !== 1'b0 || bus_rdata_en !== 1'b0 || bus_ready !== 1'b1) begin bad++; $display("FAIL filt_quiet%0d got v%b e%b r%b want v0 e0 r1", k, vdp_valid, bus_rdata_en, bus_ready); end
         vdp_rdata_en = 1;
         step();
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] exp[5];
      logic [7:0] seen[$];
      do_reset();
      for (int k = 0; k < 4; k++) begin
         exp[k] = 8'($urandom);
         req(1, 1, {8'h00, BASE[7:2], 2'(k)}, exp[k]);
         step();
      end
      exp[4] = 8'($urandom);
      req(1, 1, {8'h00, BASE[7:2], 2'd3}, exp[4]);
      vec++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", bus_ready); end
`ifdef VDP_WBUF_STAT_EN
      vec++; if (wbuf_level !== 3'd4) begin bad++; $display("FAIL full_level got %0d want 4", wbuf_level); end
`endif
      vdp_ready = 1;
      if (vdp_valid) seen.push_back(vdp_wdata);
      step();
      vec++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL full_ready_rise got %b want 1", bus_ready); end
`ifdef VDP_WBUF_STAT_EN
      vec++; if (wbuf_level !== 3'd3) begin bad++; $display("FAIL full_level3 got %0d want 3", wbuf_level); end
`endif
      if (vdp_valid) seen.push_back(vdp_wdata);
      step();
      bus_valid = 0;
      for (int k = 0; k < 8; k++) begin
         if (vdp_valid) seen.push_back(vdp_wdata);
         step();
      end
      vec++; if (seen.size() != 5) begin bad++; $display("FAIL full_count got %0d want 5", seen.size()); end
      for (int k = 0; k < 5 && k < seen.size(); k++) begin
         vec++; if (seen[k] !== exp[k]) begin bad++; $display("FAIL full_order%0d got %h want %h", k, seen[k], exp[k]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req(1, 1, 16'h0098, 8'hC1);
      step();
      req(1, 1, 16'h0099, 8'hC2);
      step();
      req(0, 1, 16'h009A, 8'h00);
      step();
      bus_valid = 0; vdp_ready = 1;
      for (int k = 0; k < 10 && !m_rd_wait; k++) step();
      vec++; if (m_rd_wait !== 1'b1 || vdp_valid !== 1'b0) begin bad++; $display("FAIL mid_rdwait got model%b v%b want model1 v0", m_rd_wait, vdp_valid); end
      reset = 1;
      #2;
      vec++; if (bus_ready !== 1'b1 || {vdp_valid, vdp_ioreq, vdp_write, bus_rdata_en} !== 4'b0) begin bad++; $display("FAIL mid_async got r%b flags %b want r1 0000", bus_ready, {vdp_valid, vdp_ioreq, vdp_write, bus_rdata_en}); end
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      m_clear();
      vdp_rdata = 8'h3C; vdp_rdata_en = 1;
      for (int k = 0; k < 2; k++) begin
         step();
         vec++; if (bus_rdata_en !== 1'b0 || bus_rdata !== 8'h00 || vdp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_return%0d got e%b %h v%b want e0 00 v0", k, bus_rdata_en, bus_rdata, vdp_valid); end
      end
      vdp_rdata_en = 0; vdp_ready = 0;
      req(1, 1, 16'h0098, 8'hD1);
      step();
      req(1, 1, 16'h009B, 8'hD2);
      step();
      bus_valid = 0;
      reset = 1;
      #2;
      vec++; if (vdp_valid !== 1'b0 || vdp_address !== 16'h0 || vdp_wdata !== 8'h0 || bus_ready !== 1'b1) begin bad++; $display("FAIL mid_writes got v%b %h %h r%b want v0 0000 00 r1", vdp_valid, vdp_address, vdp_wdata, bus_ready); end
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      m_clear();
      vdp_ready = 1;
      step();
      vec++; if (vdp_valid !== 1'b0) begin bad++; $display("FAIL mid_discard got v%b want 0", vdp_valid); end
   endtask

`ifdef VDP_WBUF_STAT_EN
   task automatic test_stat();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req(1, 1, 16'h0098, 8'(k));
         step();
      end
      bus_valid = 0;
      vec++; if (wbuf_level !== 3'd3 || wbuf_peak !== 3'd3) begin bad++; $display("FAIL stat_fill got %0d/%0d want 3/3", wbuf_level, wbuf_peak); end
      vdp_ready = 1;
      for (int k = 0; k < 4; k++) step();
      vec++; if (wbuf_level !== 3'd0 || wbuf_peak !== 3'd3) begin bad++; $display("FAIL stat_drain got %0d/%0d want 0/3", wbuf_level, wbuf_peak); end
   endtask
`endif

   task automatic test_random();
      int r;
      logic [7:0] a8;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         vec++; if (bus_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, bus_ready, m_ready()); end
         vec++; if (vdp_valid !== m_valid() || vdp_ioreq !== m_valid()) begin bad++; $display("FAIL rnd_valid cyc %0d got v%b io%b want %b", i, vdp_valid, vdp_ioreq, m_valid()); end
         if (m_valid()) begin
            vec++;
            if (vdp_write !== mq[0].w || vdp_address !== {8'h00, BASE[7:2], mq[0].p} || vdp_wdata !== mq[0].d) begin
               bad++; $display("FAIL rnd_head cyc %0d got w%b %h %h want w%b %h %h", i, vdp_write, vdp_address, vdp_wdata, mq[0].w, {8'h00, BASE[7:2], mq[0].p}, mq[0].d);
            end
         end
         vec++; if (bus_rdata_en !== m_en || bus_rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata cyc %0d got e%b %h want e%b %h", i, bus_rdata_en, bus_rdata, m_en, m_rdata); end
         r = $urandom_range(0, 9);
         if (r < 7) a8 = {BASE[7:2], 2'(r)};
         else if (r == 7) a8 = 8'hA0;
         else a8 = 8'($urandom);
         bus_valid = $urandom_range(0, 2) != 0;
         bus_address = {8'($urandom), a8};
         bus_ioreq = $urandom_range(0, 9) != 0;
         bus_write = $urandom_range(0, 3) != 0;
         bus_wdata = 8'($urandom);
         vdp_ready = $urandom_range(0, 2) != 0;
         vdp_rdata_en = $urandom_range(0, 3) == 0;
         vdp_rdata = 8'($urandom);
         step();
      end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_read_order();
      test_filter();
      test_full_pop();
      test_reset_mid();
`ifdef VDP_WBUF_STAT_EN
      test_stat();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
